// File: rtl/aes_pkg.sv
// Shared definitions for the AES block-mode decryption controller:
// default block width, chaining-mode encodings and FSM states.
package aes_pkg;

  localparam int BLOCK_W_DEF = 128;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous block FIFO with flush and occupancy count. Head entry is
// visible on rdata_o whenever the FIFO is non-empty.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int W     = BLOCK_W_DEF + 1,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == CW'(0));

endmodule

// File: rtl/aes_dec_mode_ctrl.sv
// Streams ciphertext blocks through an iterative AES decryption core one at
// a time and applies ECB or CBC chaining to the results.
module aes_dec_mode_ctrl
  import aes_pkg::*;
#(
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rest,
  input  logic               msg_start,
  input  logic               mode,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_last,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_data,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_result,
  output logic               busy,
  output logic               msg_done,
  output logic [CNT_W-1:0]   blk_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e             state_q;
  logic               mode_q;
  logic [BLOCK_W-1:0] prev_q;
  logic               last_q;
  logic [BLOCK_W-1:0] core_data_q;
  logic               core_start_q;
  logic               out_valid_q;
  logic [BLOCK_W-1:0] out_data_q;
  logic               out_last_q;
  logic               msg_done_q;
  logic               busy_q;
  logic [CNT_W-1:0]   blk_cnt_q;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [BLOCK_W:0] fifo_head;

  assign in_ready   = (fifo_count < CW'(DEPTH)) && (state_q != ST_IDLE);
  assign fifo_push  = in_valid && in_ready;
  assign fifo_pop   = (state_q == ST_ISSUE) && !fifo_empty;
  // Holding the flush for all of IDLE also drops blocks that trailed in_last.
  assign fifo_flush = (state_q == ST_IDLE);

  aes_blk_fifo #(
    .W     (BLOCK_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rest),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i ({in_last, in_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_ECB;
      prev_q       <= '0;
      last_q       <= 1'b0;
      core_data_q  <= '0;
      core_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      msg_done_q   <= 1'b0;
      busy_q       <= 1'b0;
      blk_cnt_q    <= '0;
    end else begin
      core_start_q <= 1'b0;
      msg_done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (msg_start) begin
            mode_q    <= mode;
            prev_q    <= iv;
            blk_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!fifo_empty) begin
            core_data_q  <= fifo_head[BLOCK_W-1:0];
            last_q       <= fifo_head[BLOCK_W];
            core_start_q <= 1'b1;
            state_q      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (core_done) begin
            out_data_q  <= (mode_q == MODE_CBC) ? (core_result ^ prev_q) : core_result;
            out_last_q  <= last_q;
            out_valid_q <= 1'b1;
            if (mode_q == MODE_CBC) begin
              prev_q <= core_data_q;
            end
            state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            blk_cnt_q   <= blk_cnt_q + CNT_W'(1);
            if (last_q) begin
              msg_done_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_data  = core_data_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign msg_done   = msg_done_q;
  assign busy       = busy_q;
  assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_aes_dec_mode_ctrl.sv
// Directed bench for aes_dec_mode_ctrl with an identity core model of fixed
// latency; each scenario task checks its own expected values.
module tb_aes_dec_mode_ctrl;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rest;
  logic         msg_start;
  logic         mode;
  logic [127:0] iv;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         core_start;
  logic [127:0] core_data;
  logic         core_done;
  logic [127:0] core_result;
  logic         busy;
  logic         msg_done;
  logic [3:0]   blk_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  aes_dec_mode_ctrl #(.BLOCK_W(128), .DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rest(rest), .msg_start(msg_start), .mode(mode), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_start(core_start), .core_data(core_data), .core_done(core_done),
    .core_result(core_result), .busy(busy), .msg_done(msg_done), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  // Identity core: returns its input LAT cycles after core_start; never reset.
  logic         cm_active = 1'b0;
  int           cm_cnt = 0;
  logic [127:0] cm_data = '0;
  logic         cm_done = 1'b0;
  logic         inj_done = 1'b0;
  assign core_done = cm_done | inj_done;

  always @(posedge clk) begin
    cm_done <= 1'b0;
    if (core_start) begin
      cm_active <= 1'b1;
      cm_cnt    <= LAT - 1;
      cm_data   <= core_data;
    end else if (cm_active) begin
      if (cm_cnt == 1) begin
        cm_done     <= 1'b1;
        core_result <= cm_data;
        cm_active   <= 1'b0;
      end else begin
        cm_cnt <= cm_cnt - 1;
      end
    end
  end

  int md_cnt = 0;
  int md_busy_bad = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (msg_done === 1'b1) begin
      md_cnt++;
      if (busy !== 1'b0) md_busy_bad++;
    end
    if (core_done === 1'b1) done_cnt++;
  end

  logic [127:0] feed_d[$];
  logic         feed_l[$];
  logic [127:0] got_d[$];
  logic         got_l[$];
  int feed_to = 0;
  int coll_to = 0;
  int fed_cnt = 0;

  task automatic start_msg(input logic m, input logic [127:0] v);
    @(negedge clk);
    msg_start = 1'b1; mode = m; iv = v;
    @(negedge clk);
    msg_start = 1'b0;
  endtask

  task automatic feed();
    int n;
    while (feed_d.size() > 0) begin
      in_valid = 1'b1;
      in_data  = feed_d.pop_front();
      in_last  = feed_l.pop_front();
      n = 0;
      while (!in_ready && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) begin
        feed_to++;
        feed_d.delete();
        feed_l.delete();
      end else begin
        fed_cnt++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input int n);
    int k;
    k = 0;
    while (got_d.size() < n && k < 2000) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      @(negedge clk);
      k++;
    end
    if (k >= 2000) coll_to++;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({out_valid, out_data, out_last, core_start, core_data, busy, msg_done, blk_cnt, in_ready} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: got ov=%b od=%h ol=%b cs=%b cd=%h busy=%b md=%b cnt=%h ir=%b, required all zero",
               out_valid, out_data, out_last, core_start, core_data, busy, msg_done, blk_cnt, in_ready);
    end
  endtask

  task automatic test_ecb();
    int md0;
    md0 = md_cnt;
    got_d.delete(); got_l.delete();
    out_ready = 1'b1;
    start_msg(1'b0, 128'h0);
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ecb_cycle1: got busy=%b in_ready=%b, required 1 1", busy, in_ready);
    end
    feed_d = '{128'h10, 128'h20};
    feed_l = '{1'b0, 1'b1};
    fork
      feed();
      collect(2);
    join
    repeat (2) @(negedge clk);
    tests_run++;
    if (got_d.size() != 2 || got_d[0] !== 128'h10 || got_l[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL ecb_out0: got n=%0d %h last=%b, required 2 blocks, 10 last=0", got_d.size(), got_d[0], got_l[0]);
    end
    tests_run++;
    if (got_d[1] !== 128'h20 || got_l[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL ecb_out1: got %h last=%b, required 20 last=1", got_d[1], got_l[1]);
    end
    tests_run++;
    if (md_cnt - md0 != 1 || md_busy_bad != 0) begin
      tests_failed++;
      $display("FAIL ecb_msg_done: got %0d pulses (%0d with busy), required 1 (0)", md_cnt - md0, md_busy_bad);
    end
    tests_run++;
    if (blk_cnt !== 4'd2 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ecb_blk_cnt: got cnt=%0d busy=%b, required 2 0", blk_cnt, busy);
    end
  endtask

  task automatic test_cbc();
    got_d.delete(); got_l.delete();
    out_ready = 1'b1;
    start_msg(1'b1, 128'h01);
    feed_d = '{128'h10, 128'h20, 128'h30};
    feed_l = '{1'b0, 1'b0, 1'b1};
    fork
      feed();
      collect(3);
    join
    repeat (2) @(negedge clk);
    tests_run++;
    if (got_d.size() != 3 || got_d[0] !== 128'h11 || got_d[1] !== 128'h30 || got_d[2] !== 128'h10) begin
      tests_failed++;
      $display("FAIL cbc_data: got n=%0d %h %h %h, required 11 30 10", got_d.size(), got_d[0], got_d[1], got_d[2]);
    end
    tests_run++;
    if (got_l[0] !== 1'b0 || got_l[1] !== 1'b0 || got_l[2] !== 1'b1 || blk_cnt !== 4'd3) begin
      tests_failed++;
      $display("FAIL cbc_last: got last=%b%b%b cnt=%0d, required 001 3", got_l[0], got_l[1], got_l[2], blk_cnt);
    end
  endtask

  task automatic test_abort();
    int k;
    int d0;
    int bad;
    out_ready = 1'b1;
    start_msg(1'b0, 128'h0);
    feed_d = '{128'h55};
    feed_l = '{1'b0};
    feed();
    k = 0;
    while (core_start !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests_run++;
    if (k >= 50) begin
      tests_failed++;
      $display("FAIL abort_core_start: got no core_start, required one within 50 cycles");
    end
    @(negedge clk);
    rest = 1'b1;
    repeat (3) @(negedge clk);
    rest = 1'b0;
    d0 = done_cnt;
    test_reset();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0 || done_cnt - d0 != 1) begin
      tests_failed++;
      $display("FAIL abort_late_done: got %0d active cycles, %0d late dones, required 0 and 1", bad, done_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    logic [127:0] hold;
    got_d.delete(); got_l.delete();
    out_ready = 1'b0;
    fed_cnt = 0;
    start_msg(1'b0, 128'h0);
    for (int i = 0; i < 6; i++) begin
      feed_d.push_back(128'hA1 + 128'(i));
      feed_l.push_back(i == 5);
    end
    fork
      feed();
      begin
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 100) begin
          @(negedge clk);
          k++;
        end
        hold = out_data;
        bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (out_valid !== 1'b1 || out_data !== hold || out_last !== 1'b0) bad++;
        end
        tests_run++;
        if (hold !== 128'hA1 || bad != 0) begin
          tests_failed++;
          $display("FAIL bp_hold: got first %h, %0d unstable cycles, required A1 and 0", hold, bad);
        end
        tests_run++;
        if (in_ready !== 1'b0 || fed_cnt != 5) begin
          tests_failed++;
          $display("FAIL bp_in_ready: got in_ready=%b accepted=%0d, required 0 and 5", in_ready, fed_cnt);
        end
        out_ready = 1'b1;
        collect(6);
      end
    join
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (got_d[i] !== 128'hA1 + 128'(i) || got_l[i] !== (i == 5)) bad++;
    end
    tests_run++;
    if (got_d.size() != 6 || bad != 0 || blk_cnt !== 4'd6) begin
      tests_failed++;
      $display("FAIL bp_stream: got n=%0d, %0d wrong, cnt=%0d, required 6, 0, 6", got_d.size(), bad, blk_cnt);
    end
  endtask

  task automatic test_ignored();
    int bad;
    int md0;
    md0 = md_cnt;
    got_d.delete(); got_l.delete();
    out_ready = 1'b1;
    start_msg(1'b1, 128'h01);
    @(negedge clk);
    msg_start = 1'b1; mode = 1'b0; iv = 128'hFF;
    @(negedge clk);
    msg_start = 1'b0;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || core_start !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL ign_no_output: got %0d cycles with activity, required 0", bad);
    end
    feed_d = '{128'h10, 128'h20};
    feed_l = '{1'b0, 1'b1};
    fork
      feed();
      collect(2);
    join
    repeat (5) @(negedge clk);
    tests_run++;
    if (got_d.size() != 2 || got_d[0] !== 128'h11 || got_d[1] !== 128'h30) begin
      tests_failed++;
      $display("FAIL ign_mode_iv: got n=%0d %h %h, required 11 30", got_d.size(), got_d[0], got_d[1]);
    end
    tests_run++;
    if (md_cnt - md0 != 1 || out_valid !== 1'b0 || blk_cnt !== 4'd2) begin
      tests_failed++;
      $display("FAIL ign_extra: got md=%0d ov=%b cnt=%0d, required 1 0 2", md_cnt - md0, out_valid, blk_cnt);
    end
  endtask

  task automatic test_wrap();
    int md0;
    md0 = md_cnt;
    got_d.delete(); got_l.delete();
    out_ready = 1'b1;
    start_msg(1'b0, 128'h0);
    for (int i = 1; i <= 17; i++) begin
      feed_d.push_back(128'(i));
      feed_l.push_back(i == 17);
    end
    fork
      feed();
      collect(17);
    join
    repeat (2) @(negedge clk);
    tests_run++;
    if (got_d.size() != 17 || got_d[16] !== 128'd17 || got_l[16] !== 1'b1 || got_l[15] !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_stream: got n=%0d tail=%h last=%b, required 17 11 1", got_d.size(), got_d[16], got_l[16]);
    end
    tests_run++;
    if (blk_cnt !== 4'd1 || md_cnt - md0 != 1) begin
      tests_failed++;
      $display("FAIL wrap_cnt: got cnt=%0d md=%0d, required 1 1", blk_cnt, md_cnt - md0);
    end
  endtask

  initial begin
    rest = 1'b1; msg_start = 1'b0; mode = 1'b0; iv = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    core_result = '0;
    repeat (3) @(negedge clk);
    rest = 1'b0;
    test_reset();
    test_ecb();
    test_cbc();
    test_abort();
    test_backpressure();
    test_ignored();
    test_wrap();
    tests_run++;
    if (feed_to != 0 || coll_to != 0 || md_busy_bad != 0) begin
      tests_failed++;
      $display("FAIL timeouts: got feed=%0d collect=%0d md_busy=%0d, required 0 0 0", feed_to, coll_to, md_busy_bad);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/aes_dec_mode_ctrl.md
# aes_dec_mode_ctrl

Parametrised block-mode controller that sits in front of an iterative AES decryption core and turns it into a streaming, multi-block decryptor. It buffers incoming ciphertext blocks in a small FIFO and issues them to the core one at a time over a start/done handshake. ECB and CBC chaining are applied to the core results, and plaintext is returned over a valid/ready stream with message framing. The key is wired directly to the core and does not pass through this block.

## Interface
- BLOCK_W, 128: block width in bits (data, IV, core bus).
- DEPTH, 4: input FIFO depth in blocks, power of two, ≥2.
- CNT_W, 16: width of the block counter.
- clk  in  1  clock, rising edge.
- rest  in  1  reset, synchronous, active-high.
- msg_start  in  1  start-of-message strobe, sampled only in IDLE.
- mode  in  1  0 = ECB, 1 = CBC; captured on accepted msg_start.
- iv  in  BLOCK_W  CBC initial vector; captured on accepted msg_start.
- in_valid / in_ready  in / out  1  ciphertext handshake.
- in_data  in  BLOCK_W  ciphertext block.
- in_last  in  1  marks final block of message.
- out_valid / out_ready  out / in  1  plaintext handshake.
- out_data  out  BLOCK_W  plaintext block.
- out_last  out  1  final plaintext block of message.
- core_start  out  1  one-cycle pulse launching a core decryption.
- core_data  out  BLOCK_W  ciphertext to core; stable from core_start until core_done.
- core_done  in  1  one-cycle pulse, core result valid.
- core_result  in  BLOCK_W  raw inverse-cipher output.
- busy  out  1  high whenever state ≠ IDLE.
- msg_done  out  1  one-cycle pulse when the last block is accepted downstream.
- blk_cnt  out  CNT_W  blocks emitted in the current message; wraps at 2^CNT_W.

## Operation
- FSM states: IDLE, ISSUE, WAIT, EMIT.
- IDLE: msg_start=1 captures mode and iv into chain register `prev`, clears blk_cnt, and moves to ISSUE. in_ready=0 in IDLE.
- ISSUE: if the FIFO is non-empty, pop the head into core_data and last_q, pulse core_start, and go to WAIT. Otherwise stay in ISSUE.
- WAIT: on core_done, set out_data = core_result (ECB) or core_result ^ prev (CBC), then go to EMIT with out_valid=1. In CBC mode, `prev` is updated to the popped ciphertext.
- EMIT: on out_valid & out_ready, drop out_valid, blk_cnt+1. If last_q, pulse msg_done and go to IDLE. Otherwise go to ISSUE.
- FIFO: in_ready = (count < DEPTH) && state≠IDLE, computed from the registered count. A push while full is not possible. Simultaneous push and pop keep count unchanged.
- Blocks that arrive after in_last are accepted into the FIFO only while the message is still active. Any FIFO contents remaining when the FSM returns to IDLE are flushed.
- Ignored events: msg_start outside IDLE, core_done outside WAIT, and out_ready while out_valid=0.
- out_data and out_last hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, core_start=0, core_data=0, busy=0, msg_done=0, blk_cnt=0, in_ready=0. FIFO is empty, state is IDLE, prev=0.
- rest asserted in any state aborts the message on the next edge. A core_done arriving later is ignored.
- Cycle 0: msg_start accepted. Cycle 1: busy=1, in_ready=1.
- A block pushed at cycle n can pop at the earliest at n+1 (ISSUE), with core_start at that edge.
- If core_done arrives at cycle m, out_valid=1 at m+1.
- With out_ready held high, per-block period = core latency + 3 cycles.
- msg_done is asserted in the cycle after the final out handshake, coincident with busy=0.

## Structure
- Shared package aes_pkg: BLOCK_W default, mode encoding constants (MODE_ECB=0, MODE_CBC=1), and the FSM state enum.
- One sub-module, aes_blk_fifo: synchronous FIFO with parameters BLOCK_W+1 and DEPTH, a flush input, and count output.
- The controller contains no cipher logic. The bench supplies a behavioural core model.

## Test plan
- Reset: hold rest 3 cycles mid-message. Afterwards all outputs are at reset values, and a late core_done produces no out_valid.
- ECB: identity core model with 10-cycle latency. Blocks 128'h10, 128'h20 (last) -> out 128'h10, then 128'h20 with out_last; msg_done pulses once; blk_cnt=2.
- CBC: same model, iv=128'h01. Blocks 128'h10, 128'h20, 128'h30 (last) -> out 128'h11, 128'h30, 128'h10.
- Backpressure: out_ready=0 for 20 cycles with 6 blocks offered. in_ready drops after 4 blocks are buffered, out_data holds stable, and no block is lost or duplicated.
- Ignored events: msg_start pulsed while busy, and an injected core_done in ISSUE. Neither mode nor iv changes and no extra output is produced.
- Wrap: CNT_W=4, 17 blocks -> blk_cnt reads 1 at message end.
